// File: rtl/positron_layer_ctrl.sv
// Framing and result-serialisation controller for one dense posit layer.
// Cuts the input stream into frames for the neuron array and drains captured results through a ping-pong buffer.
module positron_layer_ctrl #(
  parameter int NB_UPSTREAM_POSITRON = 784,
  parameter int NB_POSITRON          = 20,
  parameter int POSIT_WIDTH          = 16,
  parameter int NB_LANES             = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  output logic                                rtr_o,
  input  logic                                rts_i,
  input  logic                                eow_i,
  input  logic [POSIT_WIDTH-1:0]              posit_i,
  output logic                                arr_rts_o,
  output logic                                arr_sow_o,
  output logic                                arr_eow_o,
  output logic [POSIT_WIDTH-1:0]              arr_posit_o,
  input  logic                                arr_rtr_i,
  input  logic                                res_rts_i,
  input  logic                                res_eow_i,
  input  logic [NB_POSITRON*POSIT_WIDTH-1:0]  res_data_i,
  output logic                                res_rtr_o,
  input  logic                                rtr_i,
  output logic                                rts_o,
  output logic                                eow_o,
  output logic [NB_LANES*POSIT_WIDTH-1:0]     posit_o,
  output logic [NB_LANES-1:0]                 keep_o,
  output logic                                short_frame_o,
  output logic [15:0]                         frame_cnt_o
);

  localparam int NB_BEATS = (NB_POSITRON + NB_LANES - 1) / NB_LANES;
  localparam int BEAT_W   = (NB_BEATS > 1) ? $clog2(NB_BEATS) : 1;
  localparam int WC_W     = $clog2(NB_UPSTREAM_POSITRON);
  localparam int RES_W    = NB_POSITRON * POSIT_WIDTH;

  logic [WC_W-1:0]   wc_q;
  logic [15:0]       frame_cnt_q;
  logic              short_q;
  logic              tlast_q;
  logic              wr_bank_q;
  logic              rd_bank_q;
  logic [1:0]        full_q;
  logic [1:0]        tag_q;
  logic [BEAT_W-1:0] beat_q;
  logic [RES_W-1:0]  bank_q [2];

  logic accept;
  logic wc_last;
  logic capture;
  logic xfer;
  logic last_beat;

  assign rtr_o       = arr_rtr_i;
  assign arr_rts_o   = rts_i;
  assign arr_posit_o = posit_i;
  assign accept      = rts_i & arr_rtr_i;

  assign wc_last   = (wc_q == WC_W'(NB_UPSTREAM_POSITRON - 1));
  assign arr_sow_o = rts_i & (wc_q == '0);
  assign arr_eow_o = rts_i & (wc_last | eow_i);

  assign res_rtr_o = ~full_q[wr_bank_q];
  assign capture   = res_rts_i & res_eow_i & res_rtr_o;

  assign rts_o     = full_q[rd_bank_q];
  assign last_beat = (beat_q == BEAT_W'(NB_BEATS - 1));
  assign xfer      = rts_o & rtr_i;
  assign eow_o     = rts_o & tag_q[rd_bank_q] & last_beat;

  assign short_frame_o = short_q;
  assign frame_cnt_o   = frame_cnt_q;

  // Gated by rts_o so an empty or just-reset buffer presents zeros.
  always_comb begin
    posit_o = '0;
    keep_o  = '0;
    if (rts_o) begin
      for (int j = 0; j < NB_LANES; j++) begin
        if (int'(beat_q) * NB_LANES + j < NB_POSITRON) begin
          posit_o[j*POSIT_WIDTH +: POSIT_WIDTH] =
            bank_q[rd_bank_q][(int'(beat_q) * NB_LANES + j) * POSIT_WIDTH +: POSIT_WIDTH];
          keep_o[j] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wc_q        <= '0;
      frame_cnt_q <= '0;
      short_q     <= 1'b0;
      tlast_q     <= 1'b0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      full_q      <= '0;
      tag_q       <= '0;
      beat_q      <= '0;
    end else begin
      if (accept) begin
        if (arr_eow_o) begin
          wc_q        <= '0;
          frame_cnt_q <= frame_cnt_q + 16'd1;
        end else begin
          wc_q <= wc_q + WC_W'(1);
        end
      end
      short_q <= accept & eow_i & ~wc_last;

      // A capture in the same cycle as a new tlast takes the old flag value.
      if (accept & eow_i)
        tlast_q <= 1'b1;
      else if (capture)
        tlast_q <= 1'b0;

      if (capture) begin
        tag_q[wr_bank_q]  <= tlast_q;
        full_q[wr_bank_q] <= 1'b1;
        wr_bank_q         <= ~wr_bank_q;
      end

      if (xfer) begin
        if (last_beat) begin
          beat_q            <= '0;
          full_q[rd_bank_q] <= 1'b0;
          rd_bank_q         <= ~rd_bank_q;
        end else begin
          beat_q <= beat_q + BEAT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture)
      bank_q[wr_bank_q] <= res_data_i;
  end

endmodule

// File: tb/tb_positron_layer_ctrl.sv
// Directed self-checking bench for positron_layer_ctrl (UP=4, NP=5, W=16, LANES=2).
module tb_positron_layer_ctrl;
  localparam int UP    = 4;
  localparam int NP    = 5;
  localparam int W     = 16;
  localparam int LANES = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rtr_o;
  logic              rts_i;
  logic              eow_i;
  logic [W-1:0]      posit_i;
  logic              arr_rts_o;
  logic              arr_sow_o;
  logic              arr_eow_o;
  logic [W-1:0]      arr_posit_o;
  logic              arr_rtr_i;
  logic              res_rts_i;
  logic              res_eow_i;
  logic [NP*W-1:0]   res_data_i;
  logic              res_rtr_o;
  logic              rtr_i;
  logic              rts_o;
  logic              eow_o;
  logic [LANES*W-1:0] posit_o;
  logic [LANES-1:0]  keep_o;
  logic              short_frame_o;
  logic [15:0]       frame_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  positron_layer_ctrl #(
    .NB_UPSTREAM_POSITRON(UP),
    .NB_POSITRON(NP),
    .POSIT_WIDTH(W),
    .NB_LANES(LANES)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rtr_o(rtr_o), .rts_i(rts_i), .eow_i(eow_i), .posit_i(posit_i),
    .arr_rts_o(arr_rts_o), .arr_sow_o(arr_sow_o), .arr_eow_o(arr_eow_o),
    .arr_posit_o(arr_posit_o), .arr_rtr_i(arr_rtr_i),
    .res_rts_i(res_rts_i), .res_eow_i(res_eow_i), .res_data_i(res_data_i),
    .res_rtr_o(res_rtr_o),
    .rtr_i(rtr_i), .rts_o(rts_o), .eow_o(eow_o), .posit_o(posit_o), .keep_o(keep_o),
    .short_frame_o(short_frame_o), .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NP*W-1:0] mk_res(input logic [W-1:0] base);
    logic [NP*W-1:0] r;
    r = '0;
    for (int k = 0; k < NP; k++) r[k*W +: W] = base + W'(k + 1);
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; rts_i = 1'b0; eow_i = 1'b0; posit_i = '0; arr_rtr_i = 1'b1;
    res_rts_i = 1'b0; res_eow_i = 1'b0; res_data_i = '0; rtr_i = 1'b0;
    #12;
    n_checks++;
    if (rts_o !== 1'b0 || eow_o !== 1'b0 || posit_o !== '0 || keep_o !== '0) begin
      n_fail++;
      $display("FAIL reset_out: rts=%b eow=%b posit=%h keep=%b, required 0 0 0 0", rts_o, eow_o, posit_o, keep_o);
    end
    n_checks++;
    if (res_rtr_o !== 1'b1 || short_frame_o !== 1'b0 || frame_cnt_o !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_ctl: res_rtr=%b short=%b cnt=%0d, required 1 0 0", res_rtr_o, short_frame_o, frame_cnt_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_framing();
    for (int i = 0; i < 8; i++) begin
      rts_i = 1'b1; eow_i = 1'b0; posit_i = W'(16'h0100 + i);
      #1;
      n_checks++;
      if (arr_sow_o !== ((i % UP) == 0) || arr_eow_o !== ((i % UP) == UP - 1)) begin
        n_fail++;
        $display("FAIL frame_marks w%0d: sow=%b eow=%b, required %b %b", i, arr_sow_o, arr_eow_o, (i % UP) == 0, (i % UP) == UP - 1);
      end
      n_checks++;
      if (arr_rts_o !== 1'b1 || arr_posit_o !== W'(16'h0100 + i) || rtr_o !== 1'b1) begin
        n_fail++;
        $display("FAIL pass_through w%0d: rts=%b posit=%h rtr=%b", i, arr_rts_o, arr_posit_o, rtr_o);
      end
      tick();
      n_checks++;
      if (short_frame_o !== 1'b0) begin
        n_fail++;
        $display("FAIL framing_short w%0d: got %b, required 0", i, short_frame_o);
      end
    end
    rts_i = 1'b0;
    n_checks++;
    if (frame_cnt_o !== 16'd2) begin
      n_fail++;
      $display("FAIL frame_cnt: got %0d, required 2", frame_cnt_o);
    end
  endtask

  task automatic test_short();
    // One-word frame: sow and eow together.
    rts_i = 1'b1; eow_i = 1'b1;
    #1;
    n_checks++;
    if (arr_sow_o !== 1'b1 || arr_eow_o !== 1'b1) begin
      n_fail++;
      $display("FAIL one_word: sow=%b eow=%b, required 1 1", arr_sow_o, arr_eow_o);
    end
    tick();
    rts_i = 1'b0; eow_i = 1'b0;
    n_checks++;
    if (short_frame_o !== 1'b1) begin
      n_fail++;
      $display("FAIL one_word_short: got %b, required 1", short_frame_o);
    end
    tick();
    n_checks++;
    if (short_frame_o !== 1'b0 || frame_cnt_o !== 16'd3) begin
      n_fail++;
      $display("FAIL one_word_after: short=%b cnt=%0d, required 0 3", short_frame_o, frame_cnt_o);
    end
    // Three-word frame truncated by eow_i on word 2.
    for (int i = 0; i < 3; i++) begin
      rts_i = 1'b1; eow_i = (i == 2);
      #1;
      n_checks++;
      if (arr_sow_o !== (i == 0) || arr_eow_o !== (i == 2)) begin
        n_fail++;
        $display("FAIL short_marks w%0d: sow=%b eow=%b, required %b %b", i, arr_sow_o, arr_eow_o, i == 0, i == 2);
      end
      tick();
    end
    rts_i = 1'b1; eow_i = 1'b0;
    n_checks++;
    if (short_frame_o !== 1'b1) begin
      n_fail++;
      $display("FAIL short_pulse: got %b, required 1", short_frame_o);
    end
    #1;
    n_checks++;
    if (arr_sow_o !== 1'b1 || arr_eow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL short_next_sow: sow=%b eow=%b, required 1 0", arr_sow_o, arr_eow_o);
    end
    tick();
    rts_i = 1'b0;
    n_checks++;
    if (short_frame_o !== 1'b0 || frame_cnt_o !== 16'd4) begin
      n_fail++;
      $display("FAIL short_after: short=%b cnt=%0d, required 0 4", short_frame_o, frame_cnt_o);
    end
  endtask

  task automatic test_drain();
    logic [LANES*W-1:0] exp_p [3];
    logic [LANES-1:0]   exp_k [3];
    exp_p[0] = 32'h0002_0001; exp_k[0] = 2'b11;
    exp_p[1] = 32'h0004_0003; exp_k[1] = 2'b11;
    exp_p[2] = 32'h0000_0005; exp_k[2] = 2'b01;
    rtr_i = 1'b1;
    res_rts_i = 1'b1; res_eow_i = 1'b1; res_data_i = mk_res(16'h0000);
    #1;
    n_checks++;
    if (res_rtr_o !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_res_rtr: got %b, required 1", res_rtr_o);
    end
    tick();
    res_rts_i = 1'b0;
    for (int b = 0; b < 3; b++) begin
      n_checks++;
      if (rts_o !== 1'b1 || posit_o !== exp_p[b] || keep_o !== exp_k[b] || eow_o !== (b == 2)) begin
        n_fail++;
        $display("FAIL drain_beat%0d: rts=%b posit=%h keep=%b eow=%b, required 1 %h %b %b", b, rts_o, posit_o, keep_o, eow_o, exp_p[b], exp_k[b], b == 2);
      end
      tick();
    end
    n_checks++;
    if (rts_o !== 1'b0 || keep_o !== '0) begin
      n_fail++;
      $display("FAIL drain_done: rts=%b keep=%b, required 0 00", rts_o, keep_o);
    end
  endtask

  task automatic test_back_to_back();
    rtr_i = 1'b0;
    res_rts_i = 1'b1; res_eow_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      res_data_i = mk_res(W'(16'h0010 * (c + 1)));
      #1;
      n_checks++;
      if (res_rtr_o !== (c < 2)) begin
        n_fail++;
        $display("FAIL b2b_res_rtr c%0d: got %b, required %b", c, res_rtr_o, c < 2);
      end
      tick();
    end
    rtr_i = 1'b1;
    for (int b = 0; b < 3; b++) begin
      #1;
      n_checks++;
      if (res_rtr_o !== 1'b0 || rts_o !== 1'b1 || posit_o[W-1:0] !== W'(16'h0011 + 2 * b)) begin
        n_fail++;
        $display("FAIL b2b_full b%0d: res_rtr=%b rts=%b lane0=%h, required 0 1 %h", b, res_rtr_o, rts_o, posit_o[W-1:0], 16'h0011 + 2 * b);
      end
      tick();
    end
    rtr_i = 1'b0;
    #1;
    n_checks++;
    if (res_rtr_o !== 1'b1 || rts_o !== 1'b1 || posit_o !== 32'h0022_0021) begin
      n_fail++;
      $display("FAIL b2b_third: res_rtr=%b rts=%b posit=%h, required 1 1 00220021", res_rtr_o, rts_o, posit_o);
    end
    tick();
    res_rts_i = 1'b0;
    #1;
    n_checks++;
    if (res_rtr_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_after_third: res_rtr=%b, required 0", res_rtr_o);
    end
  endtask

  task automatic test_stall();
    logic               rtr_pat [9];
    logic [LANES*W-1:0] exp_p   [9];
    logic [LANES-1:0]   exp_k   [9];
    rtr_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    exp_p   = '{32'h0022_0021, 32'h0024_0023, 32'h0024_0023, 32'h0024_0023, 32'h0000_0025,
                32'h0032_0031, 32'h0034_0033, 32'h0034_0033, 32'h0000_0035};
    exp_k   = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b11, 2'b01};
    for (int i = 0; i < 9; i++) begin
      rtr_i = rtr_pat[i];
      #1;
      n_checks++;
      if (rts_o !== 1'b1 || posit_o !== exp_p[i] || keep_o !== exp_k[i] || eow_o !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_step%0d: rts=%b posit=%h keep=%b eow=%b, required 1 %h %b 0", i, rts_o, posit_o, keep_o, eow_o, exp_p[i], exp_k[i]);
      end
      tick();
    end
    n_checks++;
    if (rts_o !== 1'b0 || res_rtr_o !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_empty: rts=%b res_rtr=%b, required 0 1", rts_o, res_rtr_o);
    end
  endtask

  task automatic test_reset_mid_drain();
    rtr_i = 1'b1;
    res_rts_i = 1'b1; res_eow_i = 1'b1; res_data_i = mk_res(16'h0040);
    tick();
    res_rts_i = 1'b0;
    tick();
    n_checks++;
    if (rts_o !== 1'b1 || posit_o !== 32'h0044_0043) begin
      n_fail++;
      $display("FAIL rst_pre_beat1: rts=%b posit=%h, required 1 00440043", rts_o, posit_o);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rts_o !== 1'b0 || eow_o !== 1'b0 || keep_o !== '0 || posit_o !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_drain: rts=%b eow=%b keep=%b posit=%h, required 0 0 00 0", rts_o, eow_o, keep_o, posit_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    n_checks++;
    if (res_rtr_o !== 1'b1 || frame_cnt_o !== 16'd0 || rts_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_release: res_rtr=%b cnt=%0d rts=%b, required 1 0 0", res_rtr_o, frame_cnt_o, rts_o);
    end
  endtask

  initial begin
    test_reset();
    test_framing();
    test_short();
    test_drain();
    test_back_to_back();
    test_stall();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded 20000 time units, required completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/positron_layer_ctrl.md
Name: positron_layer_ctrl

Overview:
- Parametrised framing and result-serialisation controller for one dense posit layer. It sits between the upstream DMA/previous layer and an external array of NB_POSITRON accumulate neurons.
- It cuts the input stream into frames of NB_UPSTREAM_POSITRON words and generates sow/eow for the array. It detects short (DMA-truncated) frames.
- It captures each frame's NB_POSITRON results into a ping-pong buffer and drains them NB_LANES posits per beat, so the next frame's results are accepted while the previous one drains.

Parameters:
NB_UPSTREAM_POSITRON, 784, words per input frame (>=2)
NB_POSITRON, 20, neurons (results) per frame
POSIT_WIDTH, 16, posit word width
NB_LANES, 1, posits per output beat (1..NB_POSITRON); NB_BEATS = ceil(NB_POSITRON/NB_LANES)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rtr_o  out  1  ready to upstream
rts_i  in  1  upstream valid
eow_i  in  1  upstream DMA last word
posit_i  in  POSIT_WIDTH  upstream data
arr_rts_o  out  1  valid to neuron array
arr_sow_o  out  1  first word of frame
arr_eow_o  out  1  last word of frame
arr_posit_o  out  POSIT_WIDTH  data to array
arr_rtr_i  in  1  array ready
res_rts_i  in  1  array result valid
res_eow_i  in  1  result is final accumulation
res_data_i  in  NB_POSITRON*POSIT_WIDTH  results, neuron k at bits [k*W+:W]
res_rtr_o  out  1  result buffer can accept
rtr_i  in  1  downstream ready
rts_o  out  1  downstream valid
eow_o  out  1  DMA tlast propagated on last beat
posit_o  out  NB_LANES*POSIT_WIDTH  output beat, lane j = neuron beat*NB_LANES+j
keep_o  out  NB_LANES  valid lanes of beat
short_frame_o  out  1  one-cycle pulse: frame ended early by eow_i
frame_cnt_o  out  16  completed input frames, wraps at 65535->0

Behaviour:
- Reset: wc=0, tlast flag=0, both banks empty, wr_bank=rd_bank=0, beat=0. Reset values: rts_o=0, eow_o=0, posit_o=0, keep_o=0, short_frame_o=0, frame_cnt_o=0, res_rtr_o=1. Reset mid-drain discards buffered results.
- Input path is combinational pass-through, 0 latency:
  - rtr_o=arr_rtr_i; arr_rts_o=rts_i; arr_posit_o=posit_i.
  - Accept = rts_i & arr_rtr_i.
- Framing counter wc counts 0..NB_UPSTREAM_POSITRON-1:
  - arr_sow_o=rts_i & (wc==0).
  - arr_eow_o=rts_i & ((wc==NB_UPSTREAM_POSITRON-1) | eow_i).
  - On accept: if arr_eow_o then wc<=0, frame_cnt_o++; else wc++.
- Short frame: accept with eow_i & wc<NB_UPSTREAM_POSITRON-1 -> short_frame_o=1 next cycle, for one cycle. A 1-word frame (sow and eow together) is legal.
- DMA tlast flag: set on accept with eow_i. Cleared on result capture, which stores the flag value as the bank tag. If set and capture occur in the same cycle, the capture takes the old value and the flag ends at 1.
- Result capture:
  - res_rtr_o = NOT(full[wr_bank]).
  - Capture = res_rts_i & res_eow_i & res_rtr_o. It stores res_data_i and the tag into bank wr_bank, sets full[wr_bank], and toggles wr_bank.
  - res_rts_i without res_eow_i is ignored.
- Drain:
  - rts_o = full[rd_bank] (registered state). posit_o/keep_o are selected from bank rd_bank at index beat.
  - Lanes with index >= NB_POSITRON output 0 with keep bit 0. All other beats have keep all-ones.
  - Transfer = rts_o & rtr_i → beat++.
  - On beat==NB_BEATS-1: beat<=0, clear full[rd_bank], toggle rd_bank.
  - eow_o = rts_o & tag[rd_bank] & (beat==NB_BEATS-1).
  - Data and keep hold stable while rts_o & !rtr_i.
- Simultaneous capture into one bank and free of the other bank is legal. When both banks are full, res_rtr_o=0 until the final beat transfers. Back-pressure does not reach the input path; the array's own rtr handles it.
- Throughput: 1 beat/cycle with rtr_i held high; there is no bubble between banks.

Test Plan:
Test configuration is UP=4, NP=5, W=16, LANES=2 unless stated.
- 8 words, rts_i high, arr_rtr_i=1 -> arr_sow_o on words 0,4; arr_eow_o on words 3,7; frame_cnt_o=2; short_frame_o never.
- eow_i on word 2 of a frame -> arr_eow_o on word 2; short_frame_o pulses once; the next word raises arr_sow_o.
- Capture results 0x0001..0x0005, tag=1, rtr_i=1:
  - beat0 posit_o={0x0002,0x0001}, keep 11.
  - beat1 {0x0004,0x0003}, keep 11.
  - beat2 {0x0000,0x0005}, keep 01, eow_o=1.
- Three captures back-to-back with rtr_i=0:
  - The first two are accepted; res_rtr_o falls after the second.
  - The third is accepted only in the cycle after the bank-0 final beat transfers.
- rtr_i toggled 1,0,1 mid-drain -> posit_o holds during the stall; beat order is unchanged; no duplicate or lost beats.
- Assert rst_n low during beat1 -> rts_o, eow_o and keep_o are 0 immediately; after release res_rtr_o=1 and frame_cnt_o=0.
